layer_dense_seq: RTL



---
 rtl/layer_dense_seq.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/layer_dense_seq.sv
// Time-multiplexed fully-connected layer: one shared multiply-accumulate walks
// every (neuron, input) pair; weights/biases sit in a runtime-writable bank.
module layer_dense_seq #(
    parameter int N_IN  = 1,
    parameter int N_OUT = 6,
    parameter int IN_W  = 9,
    parameter int W_W   = 10,
    parameter int OUT_W = 16,
    parameter int ACC_W = 32,
    parameter int SHIFT = 2,
    parameter int RELU  = 0
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   cfg_we,
    input  logic [$clog2(N_IN*N_OUT+N_OUT)-1:0]    cfg_addr,
    input  logic [OUT_W-1:0]                       cfg_data,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [N_IN*IN_W-1:0]                   in_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [N_OUT*OUT_W-1:0]                 out_data,
    output logic                                   busy
);

    localparam int N_W   = N_IN * N_OUT;
    localparam int N_CFG = N_W + N_OUT;
    localparam int I_W   = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int O_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int P_W   = IN_W + W_W;

    localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t                  state;
    logic signed [W_W-1:0]   weight [N_W];
    logic signed [OUT_W-1:0] bias [N_OUT];
    logic signed [IN_W-1:0]  x [N_IN];
    logic signed [ACC_W-1:0] acc;
    logic [I_W-1:0]          idx_i;
    logic [O_W-1:0]          idx_o;

    logic signed [P_W-1:0]   prod;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W-1:0] acc_shift;
    logic signed [ACC_W:0]   biased;
    logic signed [OUT_W-1:0] result;
    int                      w_sel;
    int                      cfg_idx;

    // One extra bit on the biased sum keeps the bias add from wrapping before saturation.
    always_comb begin
        w_sel     = int'(idx_o) * N_IN + int'(idx_i);
        cfg_idx   = int'(cfg_addr);
        prod      = x[idx_i] * weight[w_sel];
        acc_next  = acc + ACC_W'(prod);
        acc_shift = acc_next >>> SHIFT;
        biased    = (ACC_W+1)'(acc_shift) + (ACC_W+1)'(bias[idx_o]);
        if (biased > SAT_MAX) begin
            result = SAT_MAX[OUT_W-1:0];
        end else if (biased < SAT_MIN) begin
            result = SAT_MIN[OUT_W-1:0];
        end else begin
            result = biased[OUT_W-1:0];
        end
        if (RELU != 0 && result[OUT_W-1]) begin
            result = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_data  <= '0;
            acc       <= '0;
            idx_i     <= '0;
            idx_o     <= '0;
            for (int k = 0; k < N_W; k++) weight[k] <= '0;
            for (int k = 0; k < N_OUT; k++) bias[k] <= '0;
            for (int k = 0; k < N_IN; k++) x[k] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A write landing on the acceptance edge is visible to the first MAC cycle.
                    if (cfg_we) begin
                        if (cfg_idx < N_W) begin
                            weight[cfg_idx] <= cfg_data[W_W-1:0];
                        end else if (cfg_idx < N_CFG) begin
                            bias[cfg_idx - N_W] <= cfg_data;
                        end
                    end
                    if (in_valid) begin
                        for (int k = 0; k < N_IN; k++) x[k] <= in_data[k*IN_W +: IN_W];
                        acc      <= '0;
                        idx_i    <= '0;
                        idx_o    <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= MAC;
                    end
                end
                MAC: begin
                    if (idx_i == I_W'(N_IN-1)) begin
                        out_data[idx_o*OUT_W +: OUT_W] <= result;
                        acc   <= '0;
                        idx_i <= '0;
                        if (idx_o == O_W'(N_OUT-1)) begin
                            idx_o     <= '0;
                            busy      <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            idx_o <= idx_o + 1'b1;
                        end
                    end else begin
                        acc   <= acc_next;
                        idx_i <= idx_i + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
